// File: rtl/alu_mul_seq.sv
// Sequential 32x32 unsigned shift-add multiplier that borrows an external 32-bit ALU for every add.
// Optional MUL_EARLY_EXIT_EN: stop iterating once the remaining multiplier bits are all zero.
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  // valid/ready: a transfer happens on a rising edge where both valid and ready
  // are high; the producer holds its data stable until then.
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     alu_a,
  output logic [WIDTH-1:0]     alu_b,
  output logic [2:0]           alu_s,
  output logic                 alu_cin,
  input  logic [WIDTH-1:0]     alu_f,
  input  logic                 alu_cout,
  output logic [1:0]           o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  logic [WIDTH-1:0]     r_mcand;
  logic [WIDTH-1:0]     r_acc;
  logic [WIDTH-1:0]     r_mq;
  logic [5:0]           r_count;
  logic [2*WIDTH-1:0]   r_product;
  logic [2*WIDTH-1:0]   w_step;

  // ALU sum and carry shift in together, so the 33-bit add result is never truncated.
  assign w_step = {alu_cout, alu_f, r_mq[WIDTH-1:1]};

`ifdef MUL_EARLY_EXIT_EN
  logic [WIDTH-1:0]     r_mrem;
  logic [2*WIDTH-1:0]   w_align;

  // Unconsumed multiplier bits in mq are zero here, so one shift lands the product.
  assign w_align = {r_acc, r_mq} >> (6'd32 - r_count);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_mcand   <= '0;
      r_acc     <= '0;
      r_mq      <= '0;
      r_count   <= '0;
      r_product <= '0;
`ifdef MUL_EARLY_EXIT_EN
      r_mrem    <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_mcand <= in_a;
            r_mq    <= in_b;
            r_acc   <= '0;
            r_count <= '0;
`ifdef MUL_EARLY_EXIT_EN
            r_mrem  <= in_b;
`endif
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
`ifdef MUL_EARLY_EXIT_EN
          if (r_mrem == '0) begin
            {r_acc, r_mq} <= w_align;
            r_product     <= w_align;
            r_state       <= S_DONE;
          end else begin
            r_mrem <= r_mrem >> 1;
`else
          begin
`endif
            {r_acc, r_mq} <= w_step;
            r_count       <= r_count + 6'd1;
            if (r_count == 6'd31) begin
              r_product <= w_step;
              r_state   <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign product     = r_product;
  assign alu_a       = (r_state == S_RUN) ? r_acc : '0;
  assign alu_b       = ((r_state == S_RUN) && r_mq[0]) ? r_mcand : '0;
  assign alu_s       = 3'd3;
  assign alu_cin     = 1'b0;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: directed vectors, a transaction-level model with an expected queue, and an ADD-only ALU stand-in.
// Expected latencies follow MUL_EARLY_EXIT_EN when it is defined for the build.
module tb_alu_mul_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] product;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_s;
  logic        alu_cin;
  logic [31:0] alu_f;
  logic        alu_cout;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  alu_mul_seq dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .product(product),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_cin(alu_cin),
    .alu_f(alu_f), .alu_cout(alu_cout), .o_dbg_state(dbg_state)
  );

  // ALU stand-in: function 3 is a plain 33-bit add.
  assign {alu_cout, alu_f} = (alu_s == 3'd3) ?
    ({1'b0, alu_a} + {1'b0, alu_b} + {32'b0, alu_cin}) : 33'h0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic int lat_of(input logic [31:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int msb;
    msb = -1;
    for (int i = 0; i < 32; i++) if (b[i]) msb = i;
    if (msb + 3 > 33) return 33;
    return msb + 3;
`else
    return 33 + 0 * int'(b[0]);
`endif
  endfunction

  // ---------------- model + scoreboard ----------------
  logic [63:0] exp_q[$];
  int          m_phase;      // 0 idle, 1 busy, 2 result held
  int          m_left;
  logic [63:0] m_prod;
  logic [31:0] m_a;
  int          e_cnt;
  int          m_last_acc;
  int          m_gap;

  always @(posedge clk) begin
    e_cnt <= e_cnt + 1;
    if (!rst_n) begin
      m_phase <= 0;
      m_left  <= 0;
      m_prod  <= 64'h0;
      m_a     <= 32'h0;
      exp_q.delete();
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          exp_q.push_back({32'h0, in_a} * {32'h0, in_b});
          m_a        <= in_a;
          m_left     <= lat_of(in_b) - 1;
          m_phase    <= 1;
          m_gap      <= e_cnt - m_last_acc;
          m_last_acc <= e_cnt;
        end
        1: begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_phase <= 2;
            m_prod  <= exp_q.pop_front();
          end
        end
        default: if (out_ready) m_phase <= 0;
      endcase
    end
  end

  // One compare process: every cycle, after reset has been applied once.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", {63'h0, in_ready}, {63'h0, m_phase == 0});
      chk("out_valid", {63'h0, out_valid}, {63'h0, m_phase == 2});
      chk("product", product, m_prod);
      chk("alu_s", {61'h0, alu_s}, 64'd3);
      chk("alu_cin", {63'h0, alu_cin}, 64'd0);
      if (m_phase != 1) begin
        chk("alu_a_idle", {32'h0, alu_a}, 64'h0);
        chk("alu_b_idle", {32'h0, alu_b}, 64'h0);
      end else if (alu_b != 32'h0) begin
        chk("alu_b_mcand", {32'h0, alu_b}, {32'h0, m_a});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at a negedge with the DUT back in idle.
  task automatic do_mul(input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_p, input int exp_lat, input int hold);
    int guard;
    int cyc;
    in_a = a; in_b = b; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 200) begin @(negedge clk); guard++; end
    if (!in_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 100) begin @(negedge clk); cyc++; end
    chk("latency", 64'(cyc), 64'(exp_lat));
    chk("result", product, exp_p);
    for (int i = 0; i < hold; i++) begin
      if (i == 3) begin in_valid = 1'b1; in_a = ~a; in_b = ~b; end
      @(negedge clk);
      chk("hold_valid", {63'h0, out_valid}, 64'd1);
      chk("hold_ready", {63'h0, in_ready}, 64'd0);
      chk("hold_product", product, exp_p);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_idle", {63'h0, in_ready}, 64'd1);
  endtask

  task automatic do_reset_mid(input logic [31:0] a, input logic [31:0] b, input int run_cycles);
    in_a = a; in_b = b; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (run_cycles) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_in_ready", {63'h0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'h0, out_valid}, 64'd0);
    chk("rst_product", product, 64'h0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] ra, rb;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    e_cnt = 0; m_last_acc = 0; m_gap = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    chk("reset_in_ready", {63'h0, in_ready}, 64'd1);
    chk("reset_out_valid", {63'h0, out_valid}, 64'd0);
    chk("reset_product", product, 64'h0);
    chk("reset_alu_a", {32'h0, alu_a}, 64'h0);

    do_mul(32'd3, 32'd5, 64'd15, 33, 0);
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 33, 10);
    do_reset_mid(32'h1234_5678, 32'h9ABC_DEF0, 15);
    do_mul(32'h1234_5678, 32'h9ABC_DEF0, 64'h0B00_EA4E_242D_2080, 33, 0);

`ifdef MUL_EARLY_EXIT_EN
    do_mul(32'hDEAD_BEEF, 32'd0, 64'd0, 2, 0);
    do_mul(32'd7, 32'd1, 64'd7, 3, 0);
`else
    do_mul(32'hDEAD_BEEF, 32'd0, 64'd0, 33, 0);
    do_mul(32'd7, 32'd1, 64'd7, 33, 0);
`endif
    do_mul(32'd5, 32'h8000_0000, 64'h0000_0002_8000_0000, 33, 0);

    for (int n = 0; n < 4; n++) begin
      ra = $urandom;
      rb = $urandom;
      do_mul(ra, rb, {32'h0, ra} * {32'h0, rb}, lat_of(rb), 0);
`ifndef MUL_EARLY_EXIT_EN
      if (n > 0) chk("issue_gap", 64'(m_gap), 64'd34);
`endif
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_mul_seq.md
# alu_mul_seq

Sequential 32x32 unsigned shift-add multiplier that sits directly upstream of the 32-bit ALU datapath. It drives the ALU's A/B/S/carry-in each cycle and consumes its sum and carry-out, so the existing ALU supplies all of its addition. Operands and the 64-bit product move over valid/ready handshakes.

## Interface
- WIDTH, 32, operand width; product is 2*WIDTH. Only 32 is supported, to match the ALU.
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  high only in IDLE
- in_a  input  32  multiplicand
- in_b  input  32  multiplier
- out_valid  output  1  product valid (DONE state)
- out_ready  input  1  consumer accepts product
- product  output  64  result, stable while out_valid is high
- alu_a  output  32  to ALU A
- alu_b  output  32  to ALU B
- alu_s  output  3  ALU function select; constant 3'd3 (ADD)
- alu_cin  output  1  ALU carry-in; constant 0
- alu_f  input  32  ALU sum, combinational in the same cycle
- alu_cout  input  1  ALU carry out of bit 31, same cycle

## Operation
- Registers: mcand[31:0], acc[31:0] (product high half), mq[31:0] (unconsumed multiplier bits, then product low half), mrem[31:0] (multiplier >> count), count[5:0].
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid: mcand<=in_a, mq<=in_b, mrem<=in_b, acc<=0, count<=0, go to RUN.
- RUN, one iteration per cycle:
  - alu_a=acc.
  - alu_b = mq[0] ? mcand : 0.
  - {acc,mq} <= {alu_cout, alu_f, mq[31:1]} >> 0, i.e. acc<={alu_cout,alu_f[31:1]} and mq<={alu_f[0],mq[31:1]}.
  - mrem<=mrem>>1; count<=count+1.
  - After the iteration with count==31 (the 32nd), go to DONE.
- DONE:
  - out_valid=1 and product={acc,mq}.
  - On out_ready, go to IDLE. The product register holds its value until the next result is written.
- Outside RUN, alu_a=0 and alu_b=0. alu_s and alu_cin are always 3'd3 and 0.
- Width rule: the 33-bit alu_cout:alu_f is shifted into the 64-bit {acc,mq} every iteration, so no carry is lost. The product is exact modulo 2^64; overflow cannot occur.
- in_valid outside IDLE is ignored (in_ready=0). Operands are sampled only on the accepting edge.
- Reset mid-operation:
  - Next edge forces IDLE; all outputs take their reset values.
  - The partial result is discarded and no out_valid is produced.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, product=0, alu_a=0, alu_b=0, alu_s=3'd3, alu_cin=0. All internal registers are 0.
- Input accepted at edge k. Without the early-exit feature, RUN occupies cycles k+1..k+32 and out_valid is high from the cycle after edge k+32.
- Latency is 33 cycles from acceptance to out_valid.
- Minimum issue interval is 34 cycles: one DONE cycle with out_ready=1, then IDLE accepts.
- out_valid and product stay stable while out_ready=0; there is no timeout.
- The ALU path is combinational within a cycle: alu_a/alu_b are registered-derived, and alu_f/alu_cout are sampled at the same edge.

## Configuration
- MUL_EARLY_EXIT_EN defined:
  - At the start of each RUN cycle, if mrem==0 the cycle performs no add. It loads {acc,mq} <= {acc,mq} >> (32-count), a one-cycle alignment, then goes to DONE.
  - Reaching count==32 still exits directly.
  - Latency is 1 + (index of highest set multiplier bit + 1) + 1 cycles, capped at 33.
  - Multiplier 0 gives out_valid 2 cycles after acceptance.
- MUL_EARLY_EXIT_EN undefined: fixed 32-iteration RUN; mrem logic is absent.

## Test plan
- Reset, then in_a=3, in_b=5 -> product=64'd15. out_valid rises exactly 33 cycles after acceptance; alu_s=3'd3 every cycle.
- in_a=in_b=32'hFFFF_FFFF -> product=64'hFFFF_FFFE_0000_0001. This exercises alu_cout on every iteration.
- out_ready held low for 10 cycles in DONE -> product and out_valid stable, in_ready=0. A new in_valid during this time is ignored; release of out_ready returns to IDLE.
- rst_n pulled low at RUN cycle 15 of 32'h1234_5678 * 32'h9ABC_DEF0 -> next cycle is IDLE with out_valid=0 and product=0. A fresh transaction then yields 64'h0B00_EA4E_242D_2080.
- MUL_EARLY_EXIT_EN defined:
  - in_b=0 -> product=0, latency 2.
  - in_a=7, in_b=1 -> product=7, latency 3.
  - in_b=32'h8000_0000 -> latency 33.
- Back-to-back: 4 random pairs issued as soon as in_ready is high, checked against a 64-bit reference model. Throughput is one result per 34 cycles with the macro undefined.
